// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch block: PC width, opcode
// encodings, FSM state type and the PCoffset9 sign-extension helper.
package fetch_pkg;

    localparam int PC_W = 16;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ADDR   = 2'b01,
        ST_UPDATE = 2'b10
    } fetch_state_t;

    function automatic logic [PC_W-1:0] sext9(input logic [8:0] off);
        return {{(PC_W-9){off[8]}}, off};
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: branch, register-indirect jump, or
// sequential increment, all modulo 2^16.
module fetch_next_pc
    import fetch_pkg::*;
(
    input  logic [PC_W-1:0] i_pc,
    input  logic [3:0]      i_opcode,
    input  logic [8:0]      i_offset,
    input  logic [PC_W-1:0] i_reg,
    input  logic [2:0]      i_br_nzp,
    input  logic [2:0]      i_result_nzp,
    output logic [PC_W-1:0] o_next_pc
);

    logic [PC_W-1:0] w_inc;
    logic            w_taken;

    assign w_inc   = i_pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign w_taken = |(i_br_nzp & i_result_nzp);

    // Select the successor PC from the opcode of the instruction just executed
    always_comb begin
        o_next_pc = w_inc;
        case (i_opcode)
            OP_BR: begin
                if (w_taken) begin
                    o_next_pc = w_inc + sext9(i_offset);
                end else begin
                    o_next_pc = w_inc;
                end
            end
            OP_JMP, OP_JSR, OP_TRAP: o_next_pc = i_reg;
            default:                 o_next_pc = w_inc;
        endcase
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch: IDLE -> ADDR -> UPDATE sequencer that presents the
// current PC as a read address, then advances the PC on leaving UPDATE.
module fetch
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_start,
    input  logic [3:0]      opCode_in,
    input  logic [8:0]      offset_in,
    input  logic [PC_W-1:0] reg_in,
    input  logic [2:0]      br_nzp,
    input  logic [2:0]      result_nzp,
    output logic [PC_W-1:0] addr_out,
    output logic            wea_out,
    output logic [PC_W-1:0] pc
);

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_addr;
    logic            r_wea;
    logic [PC_W-1:0] w_next_pc;

    fetch_next_pc u_next_pc (
        .i_pc         (r_pc),
        .i_opcode     (opCode_in),
        .i_offset     (offset_in),
        .i_reg        (reg_in),
        .i_br_nzp     (br_nzp),
        .i_result_nzp (result_nzp),
        .o_next_pc    (w_next_pc)
    );

    // Fetch sequencer; fetch_start outside IDLE is dropped, not queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= {PC_W{1'b0}};
            r_addr  <= {PC_W{1'b0}};
            r_wea   <= 1'b0;
        end else begin
            r_wea <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (fetch_start) begin
                        r_addr  <= r_pc;
                        r_state <= ST_ADDR;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    r_state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    r_pc    <= w_next_pc;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign addr_out = r_addr;
    assign wea_out  = r_wea;
    assign pc       = r_pc;

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for the fetch block.
module tb_fetch;

    logic        clk;
    logic        rst_n;
    logic        fetch_start;
    logic [3:0]  opCode_in;
    logic [8:0]  offset_in;
    logic [15:0] reg_in;
    logic [2:0]  br_nzp;
    logic [2:0]  result_nzp;
    logic [15:0] addr_out;
    logic        wea_out;
    logic [15:0] pc;

    int total = 0;
    int bad   = 0;
    logic [15:0] m_pc;

    fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_start (fetch_start),
        .opCode_in   (opCode_in),
        .offset_in   (offset_in),
        .reg_in      (reg_in),
        .br_nzp      (br_nzp),
        .result_nzp  (result_nzp),
        .addr_out    (addr_out),
        .wea_out     (wea_out),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete fetch; m_pc is the bench's model of the PC before the fetch
    task automatic do_fetch(input string tag, input logic [3:0] op, input logic [8:0] off,
                            input logic [15:0] rin, input logic [2:0] br, input logic [2:0] res,
                            input logic [15:0] exp_pc);
        opCode_in   = op;
        offset_in   = off;
        reg_in      = rin;
        br_nzp      = br;
        result_nzp  = res;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check({tag, "_addr"}, addr_out, m_pc);
        check({tag, "_wea"}, {15'd0, wea_out}, 16'h0000);
        tick();
        check({tag, "_pc_hold"}, pc, m_pc);
        tick();
        check({tag, "_pc"}, pc, exp_pc);
        m_pc = exp_pc;
    endtask

    initial begin
        rst_n       = 1'b0;
        fetch_start = 1'b0;
        opCode_in   = 4'b0000;
        offset_in   = 9'h000;
        reg_in      = 16'h0000;
        br_nzp      = 3'b000;
        result_nzp  = 3'b000;
        m_pc        = 16'h0000;

        repeat (5) tick();
        check("rst_pc", pc, 16'h0000);
        check("rst_addr", addr_out, 16'h0000);
        check("rst_wea", {15'd0, wea_out}, 16'h0000);
        rst_n = 1'b1;

        // Sequential fetches from pc=0
        do_fetch("seq_st",  4'b0011, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h0001);
        do_fetch("seq_ldr", 4'b0110, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h0002);
        do_fetch("seq_add", 4'b0001, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h0003);

        // Branch taken backwards, then not taken
        do_fetch("jmp10a",  4'b1100, 9'h000, 16'h0010, 3'b000, 3'b000, 16'h0010);
        do_fetch("br_tk",   4'b0000, 9'h1FE, 16'h0000, 3'b010, 3'b010, 16'h000F);
        do_fetch("jmp10b",  4'b1100, 9'h000, 16'h0010, 3'b000, 3'b000, 16'h0010);
        do_fetch("br_nt",   4'b0000, 9'h1FE, 16'h0000, 3'b010, 3'b100, 16'h0011);

        // Register-indirect jumps and a forward branch
        do_fetch("jmp3000", 4'b1100, 9'h000, 16'h3000, 3'b000, 3'b000, 16'h3000);
        do_fetch("st3001",  4'b0011, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h3001);
        do_fetch("jsr",     4'b0100, 9'h000, 16'h1234, 3'b000, 3'b000, 16'h1234);
        do_fetch("trap",    4'b1111, 9'h000, 16'hABCD, 3'b000, 3'b000, 16'hABCD);
        do_fetch("br_fwd",  4'b0000, 9'h005, 16'h0000, 3'b111, 3'b001, 16'hABD3);
        do_fetch("st_reg",  4'b0011, 9'h000, 16'h7777, 3'b111, 3'b111, 16'hABD4);

        // Wrap with a second fetch_start during ADDR and UPDATE
        do_fetch("jmpffff", 4'b1100, 9'h000, 16'hFFFF, 3'b000, 3'b000, 16'hFFFF);
        opCode_in   = 4'b0001;
        fetch_start = 1'b1;
        tick();
        check("wrap_addr", addr_out, 16'hFFFF);
        tick();
        fetch_start = 1'b0;
        check("wrap_pc_hold", pc, 16'hFFFF);
        tick();
        check("wrap_pc", pc, 16'h0000);
        repeat (4) tick();
        check("busy_pc", pc, 16'h0000);
        check("idle_addr", addr_out, 16'hFFFF);
        m_pc = 16'h0000;

        // Reset asserted while in ADDR
        do_fetch("jmp5555", 4'b1100, 9'h000, 16'h5555, 3'b000, 3'b000, 16'h5555);
        opCode_in   = 4'b0011;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("mid_addr_pre", addr_out, 16'h5555);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_pc", pc, 16'h0000);
        check("mid_addr", addr_out, 16'h0000);
        check("mid_wea", {15'd0, wea_out}, 16'h0000);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("mid_no_update", pc, 16'h0000);
        m_pc = 16'h0000;

        // First edge after release accepts a fetch
        do_fetch("post_rst", 4'b0011, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have these ports: clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 SHALL have rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-003 SHALL have fetch_start, input, 1 bit, a single-cycle request to fetch the next instruction.
REQ-004 SHALL have opCode_in, input, 4 bits, opcode of the instruction just executed.
REQ-005 SHALL have offset_in, input, 9 bits, the PCoffset9 field of the instruction just executed.
REQ-006 SHALL have reg_in, input, 16 bits, a resolved jump target supplied by the datapath.
REQ-007 SHALL have br_nzp, input, 3 bits, the BR instruction condition mask n,z,p.
REQ-008 SHALL have result_nzp, input, 3 bits, the current condition codes n,z,p.
REQ-009 SHALL have addr_out, output, 16 bits, the memory address, registered.
REQ-010 SHALL have wea_out, output, 1 bit, the memory write enable, registered.
REQ-011 SHALL have pc, output, 16 bits, the program counter, registered.

Function
REQ-012 SHALL implement an FSM with states IDLE, ADDR and UPDATE.
REQ-013 In IDLE, fetch_start=1 at a clock edge SHALL move the FSM to ADDR and load addr_out <= pc and wea_out <= 0 at that same edge.
REQ-014 ADDR SHALL last exactly one cycle and then go to UPDATE; addr_out SHALL hold the fetch address.
REQ-015 In UPDATE, pc SHALL load next_pc at the edge leaving UPDATE, and the FSM SHALL return to IDLE.
REQ-016 pc SHALL therefore change no earlier than the second rising edge after the edge that sampled fetch_start; at the first edge pc keeps its old value.
REQ-017 next_pc for BR (opCode_in=0000) SHALL be pc + 1 + sign-extend(offset_in) when (br_nzp & result_nzp) != 0, else pc + 1.
REQ-018 next_pc for JMP/RET (1100), JSR/JSRR (0100) and TRAP (1111) SHALL be reg_in.
REQ-019 next_pc for every other opcode (including 0011, 0110, 0001) SHALL be pc + 1.
REQ-020 All PC arithmetic SHALL be 16-bit modulo 2^16; 0xFFFF + 1 wraps to 0x0000.
REQ-021 opCode_in, offset_in, reg_in, br_nzp and result_nzp SHALL be sampled in UPDATE and SHALL be held stable by the caller from fetch_start until then.
REQ-022 fetch_start asserted while in ADDR or UPDATE SHALL be ignored, with no queuing.
REQ-023 wea_out SHALL be 0 at all times, because fetch only reads memory.
REQ-024 addr_out SHALL hold its last value while in IDLE.

Reset
REQ-025 While rst_n=0, pc, addr_out and wea_out SHALL be 0 and the FSM SHALL be in IDLE.
REQ-026 Reset asserted mid-operation (in ADDR or UPDATE) SHALL abort the fetch immediately; pc stays at 0 and no update occurs after release.
REQ-027 After rst_n rises, the block SHALL accept fetch_start on the first following clock edge.

Structure
REQ-028 A shared package SHALL hold the opcode constants (BR=0000, JSR=0100, JMP=1100, TRAP=1111, ST=0011, LDR=0110), the FSM state type and the PC width (16).
REQ-029 The combinational next-PC calculation SHALL be one sub-module, fetch_next_pc; the FSM and registers SHALL stay in fetch.

Verification
REQ-030 Reset: hold rst_n=0 for 5 cycles, release, pulse fetch_start for 1 cycle with opCode_in=0011 -> immediately after the sampling edge, addr_out=0, wea_out=0, pc=0.
REQ-031 Sequential: from pc=0, issue opCode 0011, then 0110, then 0001, one fetch_start per completed fetch -> pc=1, then 2, then 3; addr_out equals the pre-update pc of each fetch.
REQ-032 Branch: with pc=0x0010, opCode=0000, br_nzp=010, result_nzp=010 and offset=0x1FE (-2) -> pc=0x000F; with result_nzp=100 instead -> pc=0x0011.
REQ-033 Jump: opCode=1100 with reg_in=0x3000 -> pc=0x3000; then opCode=0011 -> pc=0x3001.
REQ-034 Wrap and busy: starting from pc=0xFFFF with opCode=0001 -> pc=0x0000; a second fetch_start pulse during ADDR is ignored, giving only one increment.
REQ-035 Mid-operation reset: assert rst_n=0 while in ADDR -> pc=0, addr_out=0, FSM in IDLE, and no update after release.
